// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
//   Round-robin arbiter for the write side of the asynchronous FIFO.
//   NREQ requesters share one write interface (winc/wdata). A winning
//   requester may keep the port for up to BURST consecutive words.
//   Grants are combinational and zero-latency: the granted word is written
//   in the same cycle that gnt is high. Grants are blocked while wfull is high.
//
// Ports
//   wclk          write-domain clock
//   wrst_n        synchronous active-low reset
//   req           per-requester write request
//   req_data      packed data, requester i at [i*DATASIZE +: DATASIZE]
//   wfull         FIFO full flag; no grant is issued while high
//   gnt           one-hot grant (combinational)
//   winc          FIFO write strobe (|gnt)
//   wdata         data slice of the granted requester, 0 when idle
//   owner         registered current/last burst owner index
//   burst_active  high while a burst is in progress
module fifo_wr_arbiter #(
  parameter int unsigned DATASIZE = 8,
  parameter int unsigned NREQ     = 4,
  parameter int unsigned BURST    = 4
) (
  input  logic                         wclk,
  input  logic                         wrst_n,
  input  logic [NREQ-1:0]              req,
  input  logic [NREQ*DATASIZE-1:0]     req_data,
  input  logic                         wfull,
  output logic [NREQ-1:0]              gnt,
  output logic                         winc,
  output logic [DATASIZE-1:0]          wdata,
  output logic [$clog2(NREQ)-1:0]      owner,
  output logic                         burst_active
);

  localparam int unsigned     PW        = $clog2(NREQ);
  localparam logic [PW-1:0]   LAST_IDX  = PW'(NREQ - 1);
  localparam logic [7:0]      BURST_LEN = 8'(BURST);

  typedef enum logic {ST_IDLE, ST_BURST} state_t;

  state_t         state;
  logic [PW-1:0]  rr_ptr;
  logic [7:0]     burst_cnt;
  logic [7:0]     cnt_nxt;

  logic           found_hi;
  logic           found_any;
  logic [PW-1:0]  sel_hi;
  logic [PW-1:0]  sel_any;
  logic [PW-1:0]  rr_sel;

  // Explicit wrap at NREQ-1 so non-power-of-2 NREQ stays in range.
  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] x);
    return (x == LAST_IDX) ? '0 : x + 1'b1;
  endfunction

  // Rotating priority split into two linear scans: the lowest set request
  // at or above rr_ptr wins; otherwise the lowest set request overall
  // (the wrapped part of the rotation).
  always_comb begin
    found_hi  = 1'b0;
    found_any = 1'b0;
    sel_hi    = '0;
    sel_any   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req[i] && !found_any) begin
        found_any = 1'b1;
        sel_any   = PW'(i);
      end
      if (req[i] && !found_hi && (PW'(i) >= rr_ptr)) begin
        found_hi = 1'b1;
        sel_hi   = PW'(i);
      end
    end
    rr_sel = found_hi ? sel_hi : sel_any;
  end

  always_comb begin
    gnt = '0;
    if (wrst_n && !wfull) begin
      if (state == ST_IDLE) begin
        if (found_any) gnt[rr_sel] = 1'b1;
      end else if (req[owner]) begin
        gnt[owner] = 1'b1;
      end
    end
  end

  assign winc = |gnt;

  always_comb begin
    wdata = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt[i]) wdata = req_data[i*DATASIZE +: DATASIZE];
    end
  end

  assign cnt_nxt      = burst_cnt + 8'd1;
  assign burst_active = (state == ST_BURST);

  always_ff @(posedge wclk) begin
    if (!wrst_n) begin
      state     <= ST_IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!wfull && found_any) begin
            owner <= rr_sel;
            if (BURST == 1) begin
              rr_ptr <= next_idx(rr_sel);
            end else begin
              burst_cnt <= 8'd1;
              state     <= ST_BURST;
            end
          end
        end
        ST_BURST: begin
          // While full, owner and count simply hold.
          if (!wfull) begin
            if (req[owner]) begin
              if (cnt_nxt == BURST_LEN) begin
                rr_ptr    <= next_idx(owner);
                burst_cnt <= '0;
                state     <= ST_IDLE;
              end else begin
                burst_cnt <= cnt_nxt;
              end
            end else begin
              // Owner dropped out: give up the port, costing one idle cycle.
              rr_ptr    <= next_idx(owner);
              burst_cnt <= '0;
              state     <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter: drives a BURST=1 and a BURST=4 instance
// from the same stimulus and compares both against a behavioural model.
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 8;

  logic           wclk = 1'b0;
  logic           wrst_n;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic           wfull;

  logic [N-1:0] gnt1, gnt4;
  logic         winc1, winc4;
  logic [W-1:0] wdata1, wdata4;
  logic [1:0]   owner1, owner4;
  logic         ba1, ba4;

  int n_checks = 0;
  int n_fail   = 0;

  int bv      [2] = '{1, 4};
  int m_inb   [2];
  int m_rr    [2];
  int m_owner [2];
  int m_cnt   [2];

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(.DATASIZE(W), .NREQ(N), .BURST(1)) u_b1 (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data), .wfull(wfull),
    .gnt(gnt1), .winc(winc1), .wdata(wdata1), .owner(owner1), .burst_active(ba1)
  );

  fifo_wr_arbiter #(.DATASIZE(W), .NREQ(N), .BURST(4)) u_b4 (
    .wclk(wclk), .wrst_n(wrst_n), .req(req), .req_data(req_data), .wfull(wfull),
    .gnt(gnt4), .winc(winc4), .wdata(wdata4), .owner(owner4), .burst_active(ba4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Index the model expects to be granted now, or -1 for no grant.
  function automatic int exp_grant(input int m);
    if (!wrst_n || wfull) return -1;
    if (m_inb[m] != 0) return req[m_owner[m]] ? m_owner[m] : -1;
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_rr[m] + k) % N;
      if (req[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset(input int m);
    m_inb[m] = 0; m_rr[m] = 0; m_owner[m] = 0; m_cnt[m] = 0;
  endtask

  task automatic update_model(input int m, input int e);
    if (!wrst_n) begin
      model_reset(m);
    end else if (m_inb[m] == 0) begin
      if (e >= 0) begin
        m_owner[m] = e;
        if (bv[m] == 1) m_rr[m] = (e + 1) % N;
        else begin m_cnt[m] = 1; m_inb[m] = 1; end
      end
    end else if (!wfull) begin
      if (e >= 0) begin
        m_cnt[m]++;
        if (m_cnt[m] == bv[m]) begin
          m_rr[m] = (m_owner[m] + 1) % N; m_cnt[m] = 0; m_inb[m] = 0;
        end
      end else begin
        m_rr[m] = (m_owner[m] + 1) % N; m_cnt[m] = 0; m_inb[m] = 0;
      end
    end
  endtask

  task automatic check_dut(input int m, input logic [N-1:0] g, input logic w,
                           input logic [W-1:0] d, input logic [1:0] o, input logic ba);
    int e;
    logic [N-1:0] eg;
    logic [W-1:0] ed;
    logic [N*W-1:0] rd;
    e  = exp_grant(m);
    rd = req_data;
    eg = '0;
    ed = '0;
    if (e >= 0) begin
      eg[e] = 1'b1;
      ed = rd[e*W +: W];
    end
    check($sformatf("gnt_b%0d", bv[m]), 32'(g), 32'(eg));
    check($sformatf("winc_b%0d", bv[m]), 32'(w), 32'(e >= 0));
    check($sformatf("wdata_b%0d", bv[m]), 32'(d), 32'(ed));
    check($sformatf("owner_b%0d", bv[m]), 32'(o), 32'(m_owner[m]));
    check($sformatf("burst_active_b%0d", bv[m]), 32'(ba), 32'(m_inb[m] != 0));
  endtask

  task automatic run_cycle(input logic r, input logic [N-1:0] rq, input logic f);
    int e0, e1;
    @(negedge wclk);
    wrst_n   = r;
    req      = rq;
    wfull    = f;
    req_data = $urandom;
    #1;
    check_dut(0, gnt1, winc1, wdata1, owner1, ba1);
    check_dut(1, gnt4, winc4, wdata4, owner4, ba4);
    e0 = exp_grant(0);
    e1 = exp_grant(1);
    @(posedge wclk);
    update_model(0, e0);
    update_model(1, e1);
  endtask

  initial begin
    logic [N-1:0] rq;
    wrst_n   = 1'b0;
    req      = '0;
    req_data = '0;
    wfull    = 1'b0;
    model_reset(0);
    model_reset(1);

    // Reset with all requests up, then full round-robin traffic.
    for (int c = 0; c < 3; c++) run_cycle(1'b0, 4'b1111, 1'b0);
    for (int c = 0; c < 24; c++) run_cycle(1'b1, 4'b1111, 1'b0);

    // Two sparse requesters alternate bursts.
    for (int c = 0; c < 20; c++) run_cycle(1'b1, 4'b0101, 1'b0);

    // Stall on full in the middle of traffic, then resume.
    for (int c = 0; c < 14; c++) run_cycle(1'b1, 4'b1111, 1'b0);
    for (int c = 0; c < 5; c++)  run_cycle(1'b1, 4'b1111, 1'b1);
    for (int c = 0; c < 10; c++) run_cycle(1'b1, 4'b1111, 1'b0);

    // Owner drops out mid-burst: release bubble.
    for (int c = 0; c < 2; c++) run_cycle(1'b1, 4'b0110, 1'b0);
    for (int c = 0; c < 6; c++) run_cycle(1'b1, 4'b0100, 1'b0);

    // Reset asserted mid-burst.
    for (int c = 0; c < 3; c++) run_cycle(1'b1, 4'b1111, 1'b0);
    for (int c = 0; c < 2; c++) run_cycle(1'b0, 4'b1111, 1'b0);
    for (int c = 0; c < 4; c++) run_cycle(1'b1, 4'b1111, 1'b0);

    // Randomized traffic with sticky requests, random full and rare resets.
    rq = 4'b0000;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 99) < 15) rq[i] = ~rq[i];
      run_cycle(($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1, rq,
                ($urandom_range(0, 99) < 20) ? 1'b1 : 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter in the write-clock domain of the asynchronous FIFO.
- Shares the single FIFO write interface (winc/wdata, gated by wfull) between NREQ requesters.
- Optional bounded burst ownership lets one requester stream up to BURST consecutive words before the port rotates.
- Sits directly in front of the FIFO write-pointer/full logic and the dual-port memory write port.

Parameters:
- DATASIZE, 8, word width of each requester's data and of wdata.
- NREQ, 4, number of requesters (2..16).
- BURST, 4, max consecutive words granted to one owner (1..255); 1 disables bursting.

Ports:
- wclk  input  1  write-domain clock; all state updates on rising edge.
- wrst_n  input  1  synchronous active-low reset, sampled on wclk rising edge.
- req  input  NREQ  per-requester write request; held with data stable until granted.
- req_data  input  NREQ*DATASIZE  packed data; requester i occupies bits [i*DATASIZE +: DATASIZE].
- wfull  input  1  FIFO full flag (write domain); blocks all grants when 1.
- gnt  output  NREQ  one-hot combinational grant; gnt[i]&req[i] = word i accepted this cycle.
- winc  output  1  FIFO write strobe; equals |gnt.
- wdata  output  DATASIZE  req_data slice of the granted requester; 0 when winc=0.
- owner  output  clog2(NREQ)  registered current/last burst owner index.
- burst_active  output  1  1 while in state BURST.

Behaviour:
- Registered state: fsm {IDLE, BURST}, rr_ptr (clog2(NREQ)), owner, burst_cnt (8 bits).
- Reset (wrst_n=0 at an edge): fsm=IDLE, rr_ptr=0, owner=0, burst_cnt=0.
- While wrst_n=0: gnt=0, winc=0, wdata=0 combinationally. Reset mid-burst abandons the burst; no write in that cycle.
- Grants are combinational from registered state, req and wfull. Zero-latency: the word is written in the same cycle gnt is high. The requester presents its next word or drops req in the following cycle.
- gnt is never asserted when wfull=1 or when the selected req bit is 0. At most one gnt bit is high.
- IDLE, wfull=0, req!=0:
  - Select the first set req bit scanning rr_ptr, rr_ptr+1, ..., wrapping NREQ-1 -> 0. Grant it; call it i.
  - If BURST=1: rr_ptr<=(i+1) mod NREQ; owner<=i; stay IDLE.
  - Else: owner<=i, burst_cnt<=1, fsm<=BURST.
- IDLE, wfull=1 or req=0: no grant; state unchanged.
- BURST, wfull=1: no grant; stall with owner and burst_cnt held. Ownership is retained across full.
- BURST, wfull=0, req[owner]=1: grant owner; burst_cnt<=burst_cnt+1.
  - If burst_cnt+1==BURST: rr_ptr<=(owner+1) mod NREQ, burst_cnt<=0, fsm<=IDLE.
- BURST, wfull=0, req[owner]=0: release. No grant this cycle (one bubble); rr_ptr<=(owner+1) mod NREQ, burst_cnt<=0, fsm<=IDLE. Other requesters are not served in the release cycle.
- Fairness: after any owner finishes or releases, it has lowest priority. With all req high, every requester receives exactly BURST words per rotation.
- Overflow safety relies on wfull updating the cycle after winc, which the FIFO full logic guarantees. The arbiter never writes while wfull=1.
- rr_ptr arithmetic wraps modulo NREQ; non-power-of-2 NREQ must wrap at NREQ-1, not at 2^width-1.

Test Plan:
- Reset: hold wrst_n=0 for 3 cycles with req=4'b1111 -> gnt=0, winc=0, wdata=0. First cycle after release: gnt=4'b0001, owner=0.
- BURST=1, NREQ=4, req=4'b1111 constant, data=i*16+seq -> grant order 0,1,2,3,0,...; winc=1 every cycle; wdata sequence 0x00,0x10,0x20,0x30,0x01.
- BURST=4, req=4'b0101 constant -> requester 0 gets 4 consecutive grants, then requester 2 gets 4, then requester 0. burst_active=1 during each burst; owner tracks.
- BURST=4, requester 1 drops req after 2 words -> one bubble cycle with winc=0, then requester 2 is granted (rr_ptr=2).
- wfull asserted for 5 cycles mid-burst (owner=3, burst_cnt=2) -> gnt=0, winc=0 during stall. After deassert, owner 3 completes its remaining 2 words, then rr_ptr wraps to 0.
- Reset asserted mid-burst (owner=2, burst_cnt=3) -> next cycle fsm=IDLE, rr_ptr=0, burst_active=0; no spurious winc during reset.
